operand_collect_421: RTL and testbench
======================================

OPERAND_COLLECT_421 -- requirements
Module: operand_collect_421

Interface
REQ-001 SHALL have parameter IN_WIDTH, default 32, the width of one serial operand beat.
REQ-002 SHALL have parameter SIGNED, default 1: 1 = sign-extend operands, 0 = zero-extend.
REQ-003 SHALL define localparam OUT_WIDTH = IN_WIDTH+2, the operand width presented to the 4:1 adder.
REQ-004 SHALL have port clk, input, 1: the single clock; all logic on rising edge.
REQ-005 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-006 SHALL have port in_valid, input, 1: in_data/in_last carry a beat this cycle.
REQ-007 SHALL have port in_data, input, IN_WIDTH: operand beat, order A,B,C,D.
REQ-008 SHALL have port in_last, input, 1: marks the 4th (D) beat of a group.
REQ-009 SHALL have port in_clear, input, 1: discard any partial group.
REQ-010 SHALL have port out_valid, output, 1: one-cycle pulse, A..D hold a complete group.
REQ-011 SHALL have ports A, B, C, D, output, OUT_WIDTH each: extended operands, fed straight to the adder's A..D.
REQ-012 SHALL have port err, output, 1: one-cycle pulse on a protocol error.
REQ-013 SHALL have port err_cnt, output, 16: saturating count of protocol errors.

Function
REQ-014 SHALL have no backpressure; every in_valid beat is consumed the cycle it is presented.
REQ-015 SHALL use FSM states S_A, S_B, S_C, S_D, S_RESYNC; S_A after reset.
REQ-016 SHALL, in S_A..S_C on in_valid with in_last=0, store the beat in slot A/B/C and advance to the next state.
REQ-017 SHALL, in S_D on in_valid with in_last=1, assert out_valid and update A..D on the next cycle, then return to S_A.
REQ-018 SHALL have latency 1: D beat accepted at edge t gives out_valid high for the cycle after edge t.
REQ-019 SHALL hold A..D stable between emissions; out_valid SHALL never exceed one cycle per group.
REQ-020 SHALL extend each operand by replicating in_data[IN_WIDTH-1] twice (SIGNED=1) or prepending 2'b00 (SIGNED=0).
REQ-021 SHALL treat in_valid with in_last=1 in S_A..S_C as an early-last error: drop the group including that beat, pulse err, return to S_A.
REQ-022 SHALL treat in_valid with in_last=0 in S_D as a missing-last error: drop the group, pulse err, go to S_RESYNC.
REQ-023 SHALL drop all beats in S_RESYNC until one with in_last=1, then go to S_A without emitting.
REQ-024 SHALL pulse err the cycle after the offending beat and increment err_cnt in the same cycle, saturating at 16'hFFFF.
REQ-025 SHALL, on in_clear, go to S_A and drop any partial group; no err; in_clear SHALL win over a same-cycle beat.
REQ-026 SHALL ignore in_data/in_last when in_valid=0; state unchanged.

Reset
REQ-027 SHALL, while reset=1, force state S_A, out_valid=0, err=0, err_cnt=0, A=B=C=D=0.
REQ-028 SHALL treat reset as higher priority than in_clear and in_valid; a partial group in flight during reset SHALL be lost without err.
REQ-029 SHALL accept a beat as slot A on the first edge after reset deasserts.

Structure
REQ-030 SHALL place the FSM state enum and localparam N_OPERANDS=4 in shared package adder_pkg.
REQ-031 SHALL implement the 2-bit extension in sub-module operand_ext (parameters IN_WIDTH, SIGNED), instantiated once on in_data.
REQ-032 SHALL register the extended beat directly into slot registers; no combinational path from in_* to any output.

Verification (IN_WIDTH=32)
REQ-033 SHALL cover: beats 0x00000001, 0x00000002, 0x00000003, 0x00000004 (last on 4th), SIGNED=1 -> one out_valid, A..D = 34'h1..34'h4, adder S = 10.
REQ-034 SHALL cover: beats 0x80000000 x4, SIGNED=1 -> A..D = 34'h380000000; SIGNED=0 -> 34'h080000000.
REQ-035 SHALL cover: in_last on the 2nd beat -> no out_valid, err pulse, err_cnt=1; the next 4 beats emit normally.
REQ-036 SHALL cover: 4 beats with in_last=0, then 2 more, then one with in_last=1 -> err once, no emission until a fresh group of 4.
REQ-037 SHALL cover: in_clear together with the 3rd beat, then 4 new beats -> only the new group emitted, err=0.
REQ-038 SHALL cover: 120 back-to-back random groups into the Adder_421_pipe model -> every S equals the reference sum, with reset asserted mid-group once dropping that group only.

Source files
------------

// File: rtl/adder_pkg.sv
// adder_pkg: shared operand-collector state encoding and group size
package adder_pkg;
    localparam int N_OPERANDS = 4;
    typedef enum logic [2:0] {S_A, S_B, S_C, S_D, S_RESYNC} state_t;
endpackage

// File: rtl/operand_ext.sv
// operand_ext: widen one beat by two bits, sign- or zero-extending
module operand_ext #(
    parameter int IN_WIDTH = 32,
    parameter int SIGNED   = 1
) (
    input  logic [IN_WIDTH-1:0] data,
    output logic [IN_WIDTH+1:0] ext
);
    assign ext = (SIGNED != 0) ? {{2{data[IN_WIDTH-1]}}, data} : {2'b00, data};
endmodule

// File: rtl/operand_collect_421.sv
// operand_collect_421: gather four serial beats into extended A..D for a 4:1 adder,
// dropping malformed groups and counting protocol errors
module operand_collect_421
    import adder_pkg::*;
#(
    parameter int IN_WIDTH = 32,
    parameter int SIGNED   = 1,
    localparam int OUT_WIDTH = IN_WIDTH + 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    input  logic [IN_WIDTH-1:0]  in_data,
    input  logic                 in_last,
    input  logic                 in_clear,
    output logic                 out_valid,
    output logic [OUT_WIDTH-1:0] A,
    output logic [OUT_WIDTH-1:0] B,
    output logic [OUT_WIDTH-1:0] C,
    output logic [OUT_WIDTH-1:0] D,
    output logic                 err,
    output logic [15:0]          err_cnt
);
    state_t state;
    logic [OUT_WIDTH-1:0] ext;
    logic [OUT_WIDTH-1:0] slot [N_OPERANDS-1];
    logic [15:0] err_next;

    operand_ext #(.IN_WIDTH(IN_WIDTH), .SIGNED(SIGNED)) u_ext (.data(in_data), .ext(ext));

    assign err_next = err_cnt + {15'd0, err_cnt != 16'hFFFF};

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_A;
            out_valid <= 1'b0;
            err       <= 1'b0;
            err_cnt   <= 16'd0;
            A         <= '0;
            B         <= '0;
            C         <= '0;
            D         <= '0;
        end else begin
            out_valid <= 1'b0;
            err       <= 1'b0;
            if (in_clear) begin
                state <= S_A;
            end else if (in_valid) begin
                case (state)
                    S_A, S_B, S_C: begin
                        if (in_last) begin
                            state   <= S_A;
                            err     <= 1'b1;
                            err_cnt <= err_next;
                        end else begin
                            slot[state[1:0]] <= ext;
                            state            <= state_t'(state + 3'd1);
                        end
                    end
                    S_D: begin
                        if (in_last) begin
                            A         <= slot[0];
                            B         <= slot[1];
                            C         <= slot[2];
                            D         <= ext;
                            out_valid <= 1'b1;
                            state     <= S_A;
                        end else begin
                            err     <= 1'b1;
                            err_cnt <= err_next;
                            state   <= S_RESYNC;
                        end
                    end
                    S_RESYNC: state <= in_last ? S_A : S_RESYNC;
                    default:  state <= S_A;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_operand_collect_421.sv
// tb_operand_collect_421: directed and random-group checks on signed and unsigned collectors
module tb_operand_collect_421;
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic in_valid = 1'b0;
    logic [31:0] in_data = '0;
    logic in_last = 1'b0;
    logic in_clear = 1'b0;
    logic ov_s, err_s, ov_u, err_u;
    logic [33:0] a_s, b_s, c_s, d_s, a_u, b_u, c_u, d_u;
    logic [15:0] cnt_s, cnt_u;
    int checks = 0;
    int failures = 0;
    int nov = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    operand_collect_421 #(.IN_WIDTH(32), .SIGNED(1)) u_s (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data), .in_last(in_last),
        .in_clear(in_clear), .out_valid(ov_s), .A(a_s), .B(b_s), .C(c_s), .D(d_s),
        .err(err_s), .err_cnt(cnt_s));

    operand_collect_421 #(.IN_WIDTH(32), .SIGNED(0)) u_u (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data), .in_last(in_last),
        .in_clear(in_clear), .out_valid(ov_u), .A(a_u), .B(b_u), .C(c_u), .D(d_u),
        .err(err_u), .err_cnt(cnt_u));

    function automatic logic [35:0] adder_sum();
        return {{2{a_s[33]}}, a_s} + {{2{b_s[33]}}, b_s} + {{2{c_s[33]}}, c_s} + {{2{d_s[33]}}, d_s};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
        nov += int'(ov_s);
        nerr += int'(err_s);
    endtask

    task automatic beat(input logic [31:0] d, input logic l);
        in_valid = 1'b1;
        in_data = d;
        in_last = l;
        tick();
        in_valid = 1'b0;
        in_last = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        in_valid = 1'b1;
        in_data = 32'hDEADBEEF;
        tick();
        in_last = 1'b1;
        tick();
        in_valid = 1'b0;
        in_last = 1'b0;
        checks++; if (ov_s !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", ov_s); end
        checks++; if (err_s !== 1'b0) begin failures++; $display("FAIL reset_err got=%b exp=0", err_s); end
        checks++; if (cnt_s !== 16'd0) begin failures++; $display("FAIL reset_err_cnt got=%0d exp=0", cnt_s); end
        checks++; if ({a_s, b_s, c_s, d_s} !== '0) begin failures++; $display("FAIL reset_operands got=%h exp=0", {a_s, b_s, c_s, d_s}); end
        reset = 1'b0;
    endtask

    task automatic test_basic();
        nov = 0;
        beat(32'd1, 1'b0);
        beat(32'd2, 1'b0);
        beat(32'd3, 1'b0);
        beat(32'd4, 1'b1);
        checks++; if (ov_s !== 1'b1) begin failures++; $display("FAIL basic_out_valid got=%b exp=1", ov_s); end
        checks++; if ({a_s, b_s, c_s, d_s} !== {34'h1, 34'h2, 34'h3, 34'h4}) begin failures++; $display("FAIL basic_operands got=%h %h %h %h exp=1 2 3 4", a_s, b_s, c_s, d_s); end
        checks++; if (adder_sum() !== 36'd10) begin failures++; $display("FAIL basic_sum got=%0d exp=10", adder_sum()); end
        tick();
        checks++; if (ov_s !== 1'b0 || a_s !== 34'h1 || d_s !== 34'h4) begin failures++; $display("FAIL basic_hold got ov=%b A=%h D=%h exp ov=0 A=1 D=4", ov_s, a_s, d_s); end
        checks++; if (nov !== 1) begin failures++; $display("FAIL basic_pulses got=%0d exp=1", nov); end
    endtask

    task automatic test_extension();
        for (int i = 0; i < 4; i++) beat(32'h80000000, i == 3);
        checks++; if ({a_s, b_s, c_s, d_s} !== {4{34'h380000000}}) begin failures++; $display("FAIL ext_signed got=%h %h exp=380000000", a_s, d_s); end
        checks++; if ({a_u, b_u, c_u, d_u} !== {4{34'h080000000}}) begin failures++; $display("FAIL ext_unsigned got=%h %h exp=080000000", a_u, d_u); end
        checks++; if (ov_u !== 1'b1) begin failures++; $display("FAIL ext_unsigned_valid got=%b exp=1", ov_u); end
    endtask

    task automatic test_early_last();
        nov = 0;
        nerr = 0;
        beat(32'd1, 1'b0);
        beat(32'd2, 1'b1);
        checks++; if (err_s !== 1'b1 || cnt_s !== 16'd1) begin failures++; $display("FAIL early_err got err=%b cnt=%0d exp err=1 cnt=1", err_s, cnt_s); end
        tick();
        checks++; if (err_s !== 1'b0) begin failures++; $display("FAIL early_err_pulse got=%b exp=0", err_s); end
        for (int i = 0; i < 4; i++) beat(32'(i + 5), i == 3);
        checks++; if (ov_s !== 1'b1 || a_s !== 34'h5 || d_s !== 34'h8) begin failures++; $display("FAIL early_next got ov=%b A=%h D=%h exp ov=1 A=5 D=8", ov_s, a_s, d_s); end
        checks++; if (nov !== 1 || nerr !== 1) begin failures++; $display("FAIL early_counts got ov=%0d err=%0d exp 1 1", nov, nerr); end
    endtask

    task automatic test_missing_last();
        nov = 0;
        nerr = 0;
        for (int i = 0; i < 4; i++) beat(32'(i + 100), 1'b0);
        checks++; if (err_s !== 1'b1 || cnt_s !== 16'd2) begin failures++; $display("FAIL missing_err got err=%b cnt=%0d exp err=1 cnt=2", err_s, cnt_s); end
        beat(32'd200, 1'b0);
        beat(32'd201, 1'b0);
        beat(32'd202, 1'b1);
        checks++; if (nov !== 0 || nerr !== 1) begin failures++; $display("FAIL missing_resync got ov=%0d err=%0d exp 0 1", nov, nerr); end
        for (int i = 0; i < 4; i++) beat(32'(i + 9), i == 3);
        checks++; if (ov_s !== 1'b1 || a_s !== 34'h9 || d_s !== 34'hC) begin failures++; $display("FAIL missing_next got ov=%b A=%h D=%h exp ov=1 A=9 D=c", ov_s, a_s, d_s); end
        checks++; if (nov !== 1 || cnt_s !== 16'd2) begin failures++; $display("FAIL missing_counts got ov=%0d cnt=%0d exp 1 2", nov, cnt_s); end
    endtask

    task automatic test_clear();
        nov = 0;
        nerr = 0;
        beat(32'd1, 1'b0);
        beat(32'd2, 1'b0);
        in_clear = 1'b1;
        beat(32'd3, 1'b0);
        in_clear = 1'b0;
        for (int i = 0; i < 4; i++) beat(32'(i + 20), i == 3);
        checks++; if ({a_s, b_s, c_s, d_s} !== {34'd20, 34'd21, 34'd22, 34'd23}) begin failures++; $display("FAIL clear_operands got=%h %h %h %h exp=14 15 16 17", a_s, b_s, c_s, d_s); end
        checks++; if (nov !== 1 || nerr !== 0 || cnt_s !== 16'd2) begin failures++; $display("FAIL clear_counts got ov=%0d err=%0d cnt=%0d exp 1 0 2", nov, nerr, cnt_s); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] d;
        longint ref_sum;
        logic [35:0] ref36;
        int bad = 0;
        nov = 0;
        nerr = 0;
        for (int g = 0; g < 120; g++) begin
            ref_sum = 0;
            for (int i = 0; i < 4; i++) begin
                if (g == 60 && i == 2) begin
                    reset = 1'b1;
                    tick();
                    reset = 1'b0;
                    break;
                end
                d = $urandom;
                ref_sum += longint'($signed(d));
                beat(d, i == 3);
            end
            ref36 = ref_sum[35:0];
            if (g != 60) begin
                checks++;
                if (ov_s !== 1'b1 || adder_sum() !== ref36) begin
                    failures++;
                    bad++;
                    if (bad < 5) $display("FAIL b2b_sum group=%0d got ov=%b S=%h exp ov=1 S=%h", g, ov_s, adder_sum(), ref36);
                end
            end
        end
        checks++; if (nov !== 119 || nerr !== 0) begin failures++; $display("FAIL b2b_counts got ov=%0d err=%0d exp 119 0", nov, nerr); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_extension();
        test_early_last();
        test_missing_last();
        test_clear();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
